// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable down counter with one-shot or auto-reload expiry
//
// Purpose: counts down from a loaded value and pulses expired_o for one cycle
// on terminal count. In one-shot mode it then returns to IDLE; in reload mode
// it reloads the last start value and keeps counting.
//
// Ports:
//   clk_i         clock, all state changes on rising edge
//   rst_ni        asynchronous active-low reset
//   start_i       load load_value_i and start (or restart) counting
//   load_value_i  start count, sampled only when start_i is accepted
//   pause_i       hold the count while COUNTING
//   abort_i       cancel counting and return to IDLE with out_o = 0
//   out_o         current count value
//   busy_o        1 while COUNTING
//   expired_o     registered one-cycle terminal-count pulse

module down_counter #(
  parameter int WIDTH  = 4,
  parameter int RELOAD = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             pause_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] out_o,
  output logic             busy_o,
  output logic             expired_o
);

  typedef enum logic {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expired_q, expired_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      out_q     <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
    end
  end

  // Priority: abort > start > pause > count. expired is a pulse, so it
  // defaults low and is only raised on the terminal-count edge.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    reload_d  = reload_q;
    expired_d = 1'b0;

    if (abort_i) begin
      out_d   = '0;
      state_d = IDLE;
    end else if (start_i) begin
      out_d    = load_value_i;
      reload_d = load_value_i;
      state_d  = COUNTING;
    end else if (state_q == COUNTING && !pause_i) begin
      if (out_q != '0) begin
        out_d = out_q - WIDTH'(1);
      end else begin
        // Terminal count: the zero value is held for one edge before expiry,
        // so the count never wraps to all-ones.
        expired_d = 1'b1;
        if (RELOAD != 0) begin
          out_d = reload_q;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  assign out_o     = out_q;
  assign busy_o    = (state_q == COUNTING);
  assign expired_o = expired_q;

endmodule

// File: tb/tb_down_counter.sv
// tb/tb_down_counter.sv - directed bench for down_counter, one-shot and reload
module tb_down_counter;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] load_value;
  logic         pause;
  logic         abort;

  logic [W-1:0] out_one, out_rel;
  logic         busy_one, busy_rel;
  logic         exp_one, exp_rel;

  int compared   = 0;
  int mismatched = 0;

  down_counter #(.WIDTH(W), .RELOAD(0)) u_one (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .load_value_i (load_value),
    .pause_i      (pause),
    .abort_i      (abort),
    .out_o        (out_one),
    .busy_o       (busy_one),
    .expired_o    (exp_one)
  );

  down_counter #(.WIDTH(W), .RELOAD(1)) u_rel (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .load_value_i (load_value),
    .pause_i      (pause),
    .abort_i      (abort),
    .out_o        (out_rel),
    .busy_o       (busy_rel),
    .expired_o    (exp_rel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_one(input string tag, input int o, input int b, input int e);
    check({tag, ".out"},     32'(out_one),  32'(o));
    check({tag, ".busy"},    32'(busy_one), 32'(b));
    check({tag, ".expired"}, 32'(exp_one),  32'(e));
  endtask

  task automatic chk_rel(input string tag, input int o, input int b, input int e);
    check({tag, ".out"},     32'(out_rel),  32'(o));
    check({tag, ".busy"},    32'(busy_rel), 32'(b));
    check({tag, ".expired"}, 32'(exp_rel),  32'(e));
  endtask

  task automatic do_start(input int v);
    start      = 1'b1;
    load_value = W'(v);
    step();
    start      = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    load_value = '0;
    pause      = 1'b0;
    abort      = 1'b0;

    // Reset state before any clock edge.
    #3;
    chk_one("rst_async", 0, 0, 0);
    chk_rel("rst_async_rel", 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_one("rst_idle", 0, 0, 0);

    // One-shot from 3: 3,2,1,0 then expired with busy low.
    do_start(3);
    chk_one("os3_e0", 3, 1, 0);
    step(); chk_one("os3_e1", 2, 1, 0);
    step(); chk_one("os3_e2", 1, 1, 0);
    step(); chk_one("os3_e3", 0, 1, 0);
    step(); chk_one("os3_e4", 0, 0, 1);
    step(); chk_one("os3_e5", 0, 0, 0);

    // Reload from 2: 2,1,0,2,1,0,2,1 with pulse on every reload.
    do_start(2);
    chk_rel("rl2_e0", 2, 1, 0);
    step(); chk_rel("rl2_e1", 1, 1, 0);
    step(); chk_rel("rl2_e2", 0, 1, 0);
    step(); chk_rel("rl2_e3", 2, 1, 1);
    step(); chk_rel("rl2_e4", 1, 1, 0);
    step(); chk_rel("rl2_e5", 0, 1, 0);
    step(); chk_rel("rl2_e6", 2, 1, 1);
    step(); chk_rel("rl2_e7", 1, 1, 0);
    do_abort();
    chk_rel("rl2_abort", 0, 0, 0);
    chk_one("os_abort", 0, 0, 0);

    // Pause for three edges at 3 while counting from 5.
    do_start(5);
    chk_one("pz_e0", 5, 1, 0);
    step(); chk_one("pz_e1", 4, 1, 0);
    step(); chk_one("pz_e2", 3, 1, 0);
    pause = 1'b1;
    step(); chk_one("pz_h1", 3, 1, 0);
    step(); chk_one("pz_h2", 3, 1, 0);
    step(); chk_one("pz_h3", 3, 1, 0);
    pause = 1'b0;
    step(); chk_one("pz_r2", 2, 1, 0);
    step(); chk_one("pz_r1", 1, 1, 0);
    step(); chk_one("pz_r0", 0, 1, 0);
    step(); chk_one("pz_exp", 0, 0, 1);

    // Pause on the terminal edge defers expiry.
    do_start(1);
    step(); chk_one("pt_zero", 0, 1, 0);
    pause = 1'b1;
    step(); chk_one("pt_held", 0, 1, 0);
    pause = 1'b0;
    step(); chk_one("pt_exp", 0, 0, 1);

    // Retrigger from 9 at 6 with 4, then abort+start together.
    do_start(9);
    step(); step(); step();
    chk_one("rt_at6", 6, 1, 0);
    do_start(4);
    chk_one("rt_load4", 4, 1, 0);
    step(); chk_one("rt_dec", 3, 1, 0);
    abort = 1'b1;
    do_start(7);
    abort = 1'b0;
    chk_one("rt_abort_wins", 0, 0, 0);

    // Start on the terminal edge wins with no pulse.
    do_start(1);
    step(); chk_one("st_zero", 0, 1, 0);
    do_start(2);
    chk_one("st_wins", 2, 1, 0);
    do_abort();

    // Asynchronous reset mid-count at 7.
    do_start(9);
    step(); step();
    chk_one("ar_at7", 7, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_one("ar_imm", 0, 0, 0);
    chk_rel("ar_imm_rel", 0, 0, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_one("ar_quiet", 0, 0, 0);
    end

    // Start accepted on the first edge after reset release.
    rst_n = 1'b0;
    step();
    rst_n      = 1'b1;
    do_start(2);
    chk_one("ar_first_edge", 2, 1, 0);
    do_abort();

    // Full-scale one-shot from 15 without wrap.
    do_start(15);
    chk_one("fs_e0", 15, 1, 0);
    for (int v = 14; v >= 0; v--) begin
      step();
      chk_one("fs_dec", v, 1, 0);
    end
    step(); chk_one("fs_exp", 0, 0, 1);
    step(); chk_one("fs_after", 0, 0, 0);

    // Zero load: one-shot expires after E1; reload expires every cycle.
    do_start(0);
    chk_one("z_e0", 0, 1, 0);
    chk_rel("z_e0_rel", 0, 1, 0);
    step();
    chk_one("z_e1", 0, 0, 1);
    chk_rel("z_e1_rel", 0, 1, 1);
    step(); chk_rel("z_e2_rel", 0, 1, 1);
    step(); chk_rel("z_e3_rel", 0, 1, 1);
    chk_one("z_e3", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits.
REQ-002 Parameter RELOAD, default 0: 0 = one-shot, 1 = periodic auto-reload on expiry.
REQ-003 Port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  one clock; reset is asynchronous and active-low.
REQ-005 Port start  input  1  load load_value and begin counting (retrigger if already counting).
REQ-006 Port load_value  input  WIDTH  start count, sampled only on the edge where start is accepted.
REQ-007 Port pause  input  1  hold count while 1 in COUNTING.
REQ-008 Port abort  input  1  cancel counting, return to IDLE.
REQ-009 Port out  output reg  WIDTH  current count value.
REQ-010 Port busy  output  1  1 iff state is COUNTING.
REQ-011 Port expired  output reg  1  registered one-cycle pulse on terminal count.

Function
REQ-012 FSM SHALL have exactly two states: IDLE, COUNTING; busy decoded directly from state.
REQ-013 Per-edge priority SHALL be: abort > start > pause > count.
REQ-014 abort=1, any state: out<=0, state<=IDLE, reload register unchanged, expired<=0.
REQ-015 start=1 (abort=0), any state: out<=load_value, reload register<=load_value, state<=COUNTING, expired<=0.
REQ-016 IDLE, start=0: out, state hold; expired<=0.
REQ-017 COUNTING, pause=1 (no abort/start): out and state hold; expired<=0.
REQ-018 COUNTING, pause=0, out!=0: out<=out-1; expired<=0.
REQ-019 COUNTING, pause=0, out==0, RELOAD=0: expired<=1, state<=IDLE, out stays 0.
REQ-020 COUNTING, pause=0, out==0, RELOAD=1: expired<=1, out<=reload register, state stays COUNTING.
REQ-021 Latency: start accepted on edge E0 with value L -> out=L after E0, reaches 0 after edge E(L), expired=1 for exactly the cycle after edge E(L+1) (one-shot: out=0, busy=0 in that cycle).
REQ-022 load_value=0: expired asserted after the second edge following start (E1); RELOAD=1 then expires every cycle.
REQ-023 Decrement SHALL never wrap: out==0 never becomes all-ones.
REQ-024 start on the same edge a terminal count would occur: start wins, no expired pulse.
REQ-025 pause on the same edge a terminal count would occur: expiry deferred until pause deasserts.
REQ-026 expired SHALL never be high on two consecutive cycles except RELOAD=1 with reload register 0 and pause=0.
REQ-027 All arithmetic SHALL be WIDTH bits, unsigned; load_value of 2^WIDTH-1 SHALL be supported.

Reset
REQ-028 reset=0 SHALL immediately, without a clock edge, force out=0, reload register=0, state=IDLE, busy=0, expired=0.
REQ-029 Reset asserted mid-count SHALL discard the count; no expired pulse on or after reset release.
REQ-030 First edge after reset release SHALL obey the Function rules normally (start accepted on it).

Verification
REQ-031 WIDTH=4, RELOAD=0, start with load_value=3 on E0 -> out 3,2,1,0 after E0..E3; expired=1 and busy=0 only after E4; out stays 0.
REQ-032 WIDTH=4, RELOAD=1, load_value=2 -> out 2,1,0,2,1,0...; expired pulses after every third edge following E0; busy stays 1.
REQ-033 Count from 5, pause high for 3 edges at out=3 -> out holds 3 for those edges, then resumes 2,1,0; expiry delayed by 3 cycles.
REQ-034 Count from 9, start with load_value=4 at out=6 -> out=4 next edge, no expired; abort+start same edge -> out=0, IDLE.
REQ-035 reset driven low between edges at out=7 -> out=0, busy=0 immediately; release, no start -> out stays 0, expired never asserts.
REQ-036 load_value=15 one-shot -> 15 down to 0 without wrap; load_value=0 -> expired after E1.
